// File: rtl/gfx_fb_arbiter_pkg.sv
// Shared helpers for the framebuffer arbiter: bank-select sizing and packed-slice offsets.
package gfx_fb_arbiter_pkg;

    localparam int STAT_WIDTH = 32;

    // log2 of the bank count; 0 when there is a single bank.
    function automatic int bank_sel_width(input int num_banks);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < num_banks) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Width of a bank index signal; never zero so it can always be declared.
    function automatic int bank_idx_width(input int num_banks);
        return (bank_sel_width(num_banks) > 0) ? bank_sel_width(num_banks) : 1;
    endfunction

    function automatic int local_addr_width(input int addr_width, input int num_banks);
        return addr_width - bank_sel_width(num_banks);
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/gfx_fb_arbiter_sync_fifo.sv
// Synchronous show-ahead FIFO: rdata_o presents the head entry whenever empty_o is low.
module gfx_fb_arbiter_sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/gfx_fb_arbiter.sv
// Framebuffer arbiter: display reads own their bank, buffered gfx writes fill the other banks.
// Optional statistics counters are built when GFX_FB_ARBITER_STATS_EN is defined.
module gfx_fb_arbiter
    import gfx_fb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 20,
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_BANKS     = 2,
    parameter int RD_LATENCY    = 2,
    parameter int WR_FIFO_DEPTH = 4,
    parameter int MAX_WR_STALL  = 8
) (
    input  logic                                                         clk,
    input  logic                                                         reset,
    input  logic [ADDR_WIDTH-1:0]                                        disp_addr,
    input  logic                                                         disp_valid,
    output logic                                                         disp_ready,
    output logic [DATA_WIDTH-1:0]                                        disp_rd_data,
    output logic                                                         disp_rd_valid,
    input  logic [ADDR_WIDTH-1:0]                                        gfx_addr,
    input  logic [DATA_WIDTH-1:0]                                        gfx_data,
    input  logic                                                         gfx_valid,
    output logic                                                         gfx_ready,
    output logic [NUM_BANKS-1:0]                                         bank_req,
    output logic [NUM_BANKS-1:0]                                         bank_we,
    output logic [NUM_BANKS*local_addr_width(ADDR_WIDTH, NUM_BANKS)-1:0] bank_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]                              bank_wdata,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]                              bank_rdata
`ifdef GFX_FB_ARBITER_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]                                        stat_rd_stalls,
    output logic [STAT_WIDTH-1:0]                                        stat_wr_stalls
`endif
);

    localparam int BW  = bank_sel_width(NUM_BANKS);
    localparam int BIW = bank_idx_width(NUM_BANKS);
    localparam int LAW = local_addr_width(ADDR_WIDTH, NUM_BANKS);
    localparam int EW  = ADDR_WIDTH + DATA_WIDTH;
    localparam int SCW = $clog2(MAX_WR_STALL + 1);
    localparam int PL  = RD_LATENCY + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_entry_t;

    wr_entry_t        wr_in, wr_head;
    logic [EW-1:0]    head_bits;
    logic             fifo_full, fifo_empty;
    logic             gfx_accept;

    logic [BIW-1:0]   disp_bank, head_bank;
    logic [LAW-1:0]   disp_local, head_local;
    logic             pending, force_wr, same_bank, rd_grant, wr_issue;
    logic [SCW-1:0]   stall_q, stall_d;

    logic [NUM_BANKS-1:0]            rd_hit, wr_hit;
    logic [NUM_BANKS-1:0]            bank_req_q, bank_req_d;
    logic [NUM_BANKS-1:0]            bank_we_q, bank_we_d;
    logic [NUM_BANKS*LAW-1:0]        bank_addr_q, bank_addr_d;
    logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wdata_q, bank_wdata_d;

    logic [PL-1:0]            pipe_vld_q, pipe_vld_d;
    logic [PL-1:0][BIW-1:0]   pipe_bank_q, pipe_bank_d;
    logic [DATA_WIDTH-1:0]    rd_sel;
    logic                     rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;

    // ---------------- write buffer ----------------
    assign wr_in      = '{addr: gfx_addr, data: gfx_data};
    assign gfx_ready  = !reset && !fifo_full;
    assign gfx_accept = gfx_valid && gfx_ready;
    assign wr_head    = wr_entry_t'(head_bits);

    gfx_fb_arbiter_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (WR_FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (gfx_accept),
        .wdata_i (wr_in),
        .pop_i   (wr_issue),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- address map ----------------
    assign disp_local = disp_addr[ADDR_WIDTH-1:BW];
    assign head_local = wr_head.addr[ADDR_WIDTH-1:BW];

    generate
        if (BW > 0) begin : g_bank_sel
            assign disp_bank = disp_addr[BW-1:0];
            assign head_bank = wr_head.addr[BW-1:0];
        end else begin : g_single_bank
            assign disp_bank = '0;
            assign head_bank = '0;
        end
    endgenerate

    // ---------------- arbitration ----------------
    assign pending    = !fifo_empty;
    assign force_wr   = pending && (stall_q == SCW'(MAX_WR_STALL));
    assign same_bank  = (head_bank == disp_bank);
    assign disp_ready = !reset && !(force_wr && same_bank);
    assign rd_grant   = disp_valid && disp_ready;
    assign wr_issue   = pending && (!rd_grant || !same_bank || force_wr);

    always_comb begin
        stall_d = stall_q;
        if (!pending || wr_issue) begin
            stall_d = '0;
        end else if (stall_q != SCW'(MAX_WR_STALL)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    // A read and a write only share a bank on a forced cycle, where the read is refused.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            localparam int ALO = slice_lo(gi, LAW);
            localparam int DLO = slice_lo(gi, DATA_WIDTH);
            assign rd_hit[gi]     = rd_grant && (disp_bank == BIW'(gi));
            assign wr_hit[gi]     = wr_issue && (head_bank == BIW'(gi));
            assign bank_req_d[gi] = rd_hit[gi] || wr_hit[gi];
            assign bank_we_d[gi]  = wr_hit[gi];
            assign bank_addr_d[ALO +: LAW] = wr_hit[gi] ? head_local :
                                             rd_hit[gi] ? disp_local : '0;
            assign bank_wdata_d[DLO +: DATA_WIDTH] = wr_hit[gi] ? wr_head.data : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_req_q   <= '0;
            bank_we_q    <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
        end else begin
            bank_req_q   <= bank_req_d;
            bank_we_q    <= bank_we_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
        end
    end

    assign bank_req   = bank_req_q;
    assign bank_we    = bank_we_q;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;

    // ---------------- read return ----------------
    // Stage k holds a grant from k+1 cycles ago; the last stage lines up with bank_rdata.
    generate
        for (genvar gi = 0; gi < PL; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_vld_d[gi]  = rd_grant;
                assign pipe_bank_d[gi] = disp_bank;
            end else begin : g_tail
                assign pipe_vld_d[gi]  = pipe_vld_q[gi-1];
                assign pipe_bank_d[gi] = pipe_bank_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        rd_sel = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (pipe_bank_q[PL-1] == BIW'(b)) begin
                rd_sel = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rd_valid_d = pipe_vld_q[PL-1];
    assign rd_data_d  = pipe_vld_q[PL-1] ? rd_sel : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_q  <= '0;
            pipe_bank_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_bank_q <= pipe_bank_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign disp_rd_valid = rd_valid_q;
    assign disp_rd_data  = rd_data_q;

`ifdef GFX_FB_ARBITER_STATS_EN
    logic [STAT_WIDTH-1:0] rd_stall_cnt_q, rd_stall_cnt_d;
    logic [STAT_WIDTH-1:0] wr_stall_cnt_q, wr_stall_cnt_d;

    always_comb begin
        rd_stall_cnt_d = rd_stall_cnt_q;
        wr_stall_cnt_d = wr_stall_cnt_q;
        if (disp_valid && !disp_ready && (rd_stall_cnt_q != '1)) begin
            rd_stall_cnt_d = rd_stall_cnt_q + 1'b1;
        end
        if (pending && !wr_issue && (wr_stall_cnt_q != '1)) begin
            wr_stall_cnt_d = wr_stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stall_cnt_q <= '0;
            wr_stall_cnt_q <= '0;
        end else begin
            rd_stall_cnt_q <= rd_stall_cnt_d;
            wr_stall_cnt_q <= wr_stall_cnt_d;
        end
    end

    assign stat_rd_stalls = rd_stall_cnt_q;
    assign stat_wr_stalls = wr_stall_cnt_q;
`endif

endmodule

// File: tb/tb_gfx_fb_arbiter.sv
// Directed bench for gfx_fb_arbiter (2 banks, read latency 2) with a behavioural bank model.
// Statistics outputs are checked when GFX_FB_ARBITER_STATS_EN is defined.
module tb_gfx_fb_arbiter;

    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int NB  = 2;
    localparam int RL  = 2;
    localparam int LAW = AW - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     disp_addr;
    logic              disp_valid;
    logic              disp_ready;
    logic [DW-1:0]     disp_rd_data;
    logic              disp_rd_valid;
    logic [AW-1:0]     gfx_addr;
    logic [DW-1:0]     gfx_data;
    logic              gfx_valid;
    logic              gfx_ready;
    logic [NB-1:0]     bank_req;
    logic [NB-1:0]     bank_we;
    logic [NB*LAW-1:0] bank_addr;
    logic [NB*DW-1:0]  bank_wdata;
    logic [NB*DW-1:0]  bank_rdata;
`ifdef GFX_FB_ARBITER_STATS_EN
    logic [31:0]       stat_rd_stalls;
    logic [31:0]       stat_wr_stalls;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gfx_fb_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .NUM_BANKS     (NB),
        .RD_LATENCY    (RL),
        .WR_FIFO_DEPTH (4),
        .MAX_WR_STALL  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .disp_addr     (disp_addr),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_rd_data  (disp_rd_data),
        .disp_rd_valid (disp_rd_valid),
        .gfx_addr      (gfx_addr),
        .gfx_data      (gfx_data),
        .gfx_valid     (gfx_valid),
        .gfx_ready     (gfx_ready),
        .bank_req      (bank_req),
        .bank_we       (bank_we),
        .bank_addr     (bank_addr),
        .bank_wdata    (bank_wdata),
        .bank_rdata    (bank_rdata)
`ifdef GFX_FB_ARBITER_STATS_EN
        ,
        .stat_rd_stalls (stat_rd_stalls),
        .stat_wr_stalls (stat_wr_stalls)
`endif
    );

    // Bank model: unwritten words read back as their own global address.
    logic [DW-1:0] mem     [NB][64];
    logic          written [NB][64];
    logic [DW-1:0] rd_pipe [NB][RL];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req[b] && bank_we[b]) begin
                mem[b][bank_addr[b*LAW +: 6]]     <= bank_wdata[b*DW +: DW];
                written[b][bank_addr[b*LAW +: 6]] <= 1'b1;
            end
            if (bank_req[b] && !bank_we[b]) begin
                rd_pipe[b][0] <= (written[b][bank_addr[b*LAW +: 6]] === 1'b1)
                                 ? mem[b][bank_addr[b*LAW +: 6]]
                                 : DW'({bank_addr[b*LAW +: LAW], 1'(b)});
            end else begin
                rd_pipe[b][0] <= 16'hDEAD;
            end
            for (int s = 1; s < RL; s++) begin
                rd_pipe[b][s] <= rd_pipe[b][s-1];
            end
        end
    end

    always_comb begin
        bank_rdata = '0;
        for (int b = 0; b < NB; b++) begin
            bank_rdata[b*DW +: DW] = rd_pipe[b][RL-1];
        end
    end

    // Log of every write that reaches a bank, in arrival order.
    logic [AW-1:0] log_addr [64];
    logic [DW-1:0] log_data [64];
    int            log_n = 0;

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req[b] && bank_we[b]) begin
                log_addr[log_n[5:0]] <= {bank_addr[b*LAW +: LAW], 1'(b)};
                log_data[log_n[5:0]] <= bank_wdata[b*DW +: DW];
                log_n <= log_n + 1;
                $display("bank%0d write addr=%05h data=%04h", b,
                         {bank_addr[b*LAW +: LAW], 1'(b)}, bank_wdata[b*DW +: DW]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0;
        disp_addr  = '0;
        gfx_valid  = 1'b0;
        gfx_addr   = '0;
        gfx_data   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (gfx_ready !== 1'b0) $display("FAIL reset_gfx_ready_in: got %b expected 0", gfx_ready); else n_pass++;
        n_checks++; if (disp_ready !== 1'b0) $display("FAIL reset_disp_ready_in: got %b expected 0", disp_ready); else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (gfx_ready !== 1'b1) $display("FAIL reset_gfx_ready: got %b expected 1", gfx_ready); else n_pass++;
        n_checks++; if (disp_ready !== 1'b1) $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); else n_pass++;
        n_checks++; if (bank_req !== 2'b00) $display("FAIL reset_bank_req: got %b expected 00", bank_req); else n_pass++;
        n_checks++; if (bank_we !== 2'b00) $display("FAIL reset_bank_we: got %b expected 00", bank_we); else n_pass++;
        n_checks++; if (bank_addr !== '0) $display("FAIL reset_bank_addr: got %h expected 0", bank_addr); else n_pass++;
        n_checks++; if (bank_wdata !== '0) $display("FAIL reset_bank_wdata: got %h expected 0", bank_wdata); else n_pass++;
        n_checks++; if (disp_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b expected 0", disp_rd_valid); else n_pass++;
        n_checks++; if (disp_rd_data !== '0) $display("FAIL reset_rd_data: got %h expected 0", disp_rd_data); else n_pass++;
        tick();
    endtask

    task automatic test_reads();
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            disp_valid = (i < 16);
            disp_addr  = AW'(i);
            @(negedge clk);
            if (i < 16) begin
                n_checks++; if (disp_ready !== 1'b1) $display("FAIL reads_ready[%0d]: got %b expected 1", i, disp_ready); else n_pass++;
            end
            n_checks++;
            if (disp_rd_valid !== (i >= 4 && i < 20))
                $display("FAIL reads_valid[%0d]: got %b expected %b", i, disp_rd_valid, (i >= 4 && i < 20));
            else n_pass++;
            if (i >= 4 && i < 20) begin
                n_checks++;
                if (disp_rd_data !== DW'(i - 4))
                    $display("FAIL reads_data[%0d]: got %h expected %h", i, disp_rd_data, DW'(i - 4));
                else n_pass++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_parallel();
        do_reset();
        gfx_valid = 1'b1; gfx_addr = 20'd1; gfx_data = 16'hABCD;
        @(negedge clk);
        n_checks++; if (gfx_ready !== 1'b1) $display("FAIL par_gfx_ready: got %b expected 1", gfx_ready); else n_pass++;
        tick();
        gfx_valid = 1'b0;
        disp_valid = 1'b1; disp_addr = 20'd0;
        @(negedge clk);
        n_checks++; if (disp_ready !== 1'b1) $display("FAIL par_disp_ready: got %b expected 1", disp_ready); else n_pass++;
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bank_req !== 2'b11) $display("FAIL par_bank_req: got %b expected 11", bank_req); else n_pass++;
        n_checks++; if (bank_we !== 2'b10) $display("FAIL par_bank_we: got %b expected 10", bank_we); else n_pass++;
        n_checks++; if (bank_wdata[DW +: DW] !== 16'hABCD) $display("FAIL par_wdata1: got %h expected abcd", bank_wdata[DW +: DW]); else n_pass++;
        n_checks++; if (bank_addr[LAW +: LAW] !== '0) $display("FAIL par_addr1: got %h expected 0", bank_addr[LAW +: LAW]); else n_pass++;
        n_checks++; if (bank_addr[0 +: LAW] !== '0) $display("FAIL par_addr0: got %h expected 0", bank_addr[0 +: LAW]); else n_pass++;
        tick();
        disp_valid = 1'b1; disp_addr = 20'd1;
        @(negedge clk);
        n_checks++; if (disp_ready !== 1'b1) $display("FAIL par_disp_ready2: got %b expected 1", disp_ready); else n_pass++;
        tick();
        disp_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bank_req !== 2'b10 || bank_we !== 2'b00) $display("FAIL par_read1_cmd: got req=%b we=%b expected req=10 we=00", bank_req, bank_we); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (disp_rd_valid !== 1'b1 || disp_rd_data !== 16'h0000) $display("FAIL par_read0: got v=%b d=%h expected v=1 d=0000", disp_rd_valid, disp_rd_data); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (disp_rd_valid !== 1'b0) $display("FAIL par_gap: got %b expected 0", disp_rd_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (disp_rd_valid !== 1'b1 || disp_rd_data !== 16'hABCD) $display("FAIL par_read1: got v=%b d=%h expected v=1 d=abcd", disp_rd_valid, disp_rd_data); else n_pass++;
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        for (int i = 0; i <= 13; i++) begin
            disp_valid = (i <= 11);
            disp_addr  = 20'd4;
            gfx_valid  = (i == 0);
            gfx_addr   = 20'd2;
            gfx_data   = 16'h1234;
            @(negedge clk);
            if (i == 0) begin
                n_checks++; if (gfx_ready !== 1'b1) $display("FAIL conf_gfx_ready: got %b expected 1", gfx_ready); else n_pass++;
            end
            if (i <= 11) begin
                n_checks++;
                if (disp_ready !== (i != 9))
                    $display("FAIL conf_disp_ready[%0d]: got %b expected %b", i, disp_ready, (i != 9));
                else n_pass++;
            end
            if (i == 10) begin
                n_checks++;
                if (bank_req !== 2'b01 || bank_we !== 2'b01 || bank_addr[0 +: LAW] !== LAW'(1) || bank_wdata[0 +: DW] !== 16'h1234)
                    $display("FAIL conf_write_cmd: got req=%b we=%b a=%h d=%h expected req=01 we=01 a=1 d=1234",
                             bank_req, bank_we, bank_addr[0 +: LAW], bank_wdata[0 +: DW]);
                else n_pass++;
            end else if (i >= 1) begin
                n_checks++; if (bank_we !== 2'b00) $display("FAIL conf_no_write[%0d]: got %b expected 00", i, bank_we); else n_pass++;
            end
            tick();
        end
        idle_inputs();
`ifdef GFX_FB_ARBITER_STATS_EN
        @(negedge clk);
        n_checks++; if (stat_wr_stalls !== 32'd8) $display("FAIL stat_wr_stalls: got %0d expected 8", stat_wr_stalls); else n_pass++;
        n_checks++; if (stat_rd_stalls !== 32'd1) $display("FAIL stat_rd_stalls: got %0d expected 1", stat_rd_stalls); else n_pass++;
`endif
        // Read the written word back.
        disp_valid = 1'b1; disp_addr = 20'd2;
        @(negedge clk);
        tick();
        disp_valid = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (disp_rd_valid !== 1'b1 || disp_rd_data !== 16'h1234) $display("FAIL conf_readback: got v=%b d=%h expected v=1 d=1234", disp_rd_valid, disp_rd_data); else n_pass++;
        tick();
    endtask

    task automatic test_fifo_full();
        int base;
        int k;
        logic accepted;
        do_reset();
        base = log_n;
        k = 0;
        for (int i = 0; i <= 20; i++) begin
            disp_valid = (i <= 10);
            disp_addr  = 20'h10;
            gfx_valid  = (k < 5);
            gfx_addr   = AW'(k * 2);
            gfx_data   = DW'(16'h5000 + k);
            @(negedge clk);
            if (i == 4 || i == 9) begin
                n_checks++; if (gfx_ready !== 1'b0) $display("FAIL full_gfx_ready[%0d]: got %b expected 0", i, gfx_ready); else n_pass++;
            end
            if (i == 9) begin
                n_checks++; if (disp_ready !== 1'b0) $display("FAIL full_force_ready: got %b expected 0", disp_ready); else n_pass++;
            end
            if (i == 10) begin
                n_checks++; if (gfx_ready !== 1'b1) $display("FAIL full_gfx_ready_back: got %b expected 1", gfx_ready); else n_pass++;
            end
            accepted = gfx_valid && gfx_ready;
            tick();
            if (accepted) k++;
        end
        idle_inputs();
        n_checks++; if (log_n - base !== 5) $display("FAIL full_write_count: got %0d expected 5", log_n - base); else n_pass++;
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (log_addr[6'(base + j)] !== AW'(j * 2) || log_data[6'(base + j)] !== DW'(16'h5000 + j))
                $display("FAIL full_order[%0d]: got a=%h d=%h expected a=%h d=%h", j,
                         log_addr[6'(base + j)], log_data[6'(base + j)], AW'(j * 2), DW'(16'h5000 + j));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = log_n;
        for (int i = 0; i < 3; i++) begin
            disp_valid = 1'b1;
            disp_addr  = AW'(i * 2);
            gfx_valid  = 1'b1;
            gfx_addr   = AW'(32 + i * 2);
            gfx_data   = DW'(16'h7000 + i);
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (gfx_ready !== 1'b0) $display("FAIL mid_gfx_ready_in: got %b expected 0", gfx_ready); else n_pass++;
        n_checks++; if (disp_ready !== 1'b0) $display("FAIL mid_disp_ready_in: got %b expected 0", disp_ready); else n_pass++;
        tick();
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0) begin
                n_checks++; if (gfx_ready !== 1'b1) $display("FAIL mid_gfx_ready: got %b expected 1", gfx_ready); else n_pass++;
                n_checks++; if (disp_ready !== 1'b1) $display("FAIL mid_disp_ready: got %b expected 1", disp_ready); else n_pass++;
            end
            n_checks++; if (disp_rd_valid !== 1'b0) $display("FAIL mid_rd_valid[%0d]: got %b expected 0", j, disp_rd_valid); else n_pass++;
            n_checks++; if (bank_req !== 2'b00) $display("FAIL mid_bank_req[%0d]: got %b expected 00", j, bank_req); else n_pass++;
            tick();
        end
        n_checks++; if (log_n !== base) $display("FAIL mid_no_writes: got %0d expected %0d", log_n, base); else n_pass++;
        // A fresh write must be the first one out if the buffer was emptied.
        gfx_valid = 1'b1; gfx_addr = 20'h30; gfx_data = 16'h7777;
        @(negedge clk);
        n_checks++; if (gfx_ready !== 1'b1) $display("FAIL mid_fresh_ready: got %b expected 1", gfx_ready); else n_pass++;
        tick();
        gfx_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (log_n !== base + 1 || log_addr[6'(base)] !== 20'h30 || log_data[6'(base)] !== 16'h7777)
            $display("FAIL mid_fresh_write: got n=%0d a=%h d=%h expected n=%0d a=00030 d=7777",
                     log_n - base, log_addr[6'(base)], log_data[6'(base)], 1);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_reads();
        test_parallel();
        test_conflict();
        test_fifo_full();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
